// File: rtl/transpose_midi_ch.sv
// Per-channel MIDI note transposer with deferred shift updates and a
// single-entry registered output stage; SysEx is a combinational pass-through.
module transpose_midi_ch #(
   parameter int unsigned SHIFT_W       = 5,
   parameter int          DEFAULT_SHIFT = 0,
   parameter logic [15:0] CH_MASK       = 16'hFFFF,
   parameter bit          OOR_CLAMP     = 1'b0,
   parameter int unsigned CNT_W         = 8
) (
   input  logic               aclk,
   input  logic               aresetn,
   input  logic [3:0]         midi_in_midi_cmd,
   input  logic [3:0]         midi_in_midi_ch,
   input  logic [6:0]         midi_in_midi_data1,
   input  logic [6:0]         midi_in_midi_data2,
   input  logic               midi_in_midi_valid,
   output logic               midi_in_midi_rd,
   output logic               midi_in_midi_busy,
   output logic [3:0]         midi_out_midi_cmd,
   output logic [3:0]         midi_out_midi_ch,
   output logic [6:0]         midi_out_midi_data1,
   output logic [6:0]         midi_out_midi_data2,
   output logic               midi_out_midi_valid,
   input  logic               midi_out_midi_rd,
   input  logic               midi_out_midi_busy,
   input  logic [7:0]         midi_in_sysex_data,
   input  logic               midi_in_sysex_valid,
   input  logic               midi_in_sysex_last,
   output logic               midi_in_sysex_rd,
   output logic               midi_in_sysex_busy,
   output logic [7:0]         midi_out_sysex_data,
   output logic               midi_out_sysex_valid,
   output logic               midi_out_sysex_last,
   input  logic               midi_out_sysex_rd,
   input  logic               midi_out_sysex_busy,
   input  logic               cfg_wr,
   input  logic [3:0]         cfg_ch,
   input  logic [SHIFT_W-1:0] cfg_shift,
   output logic [15:0]        notes_active,
   output logic [15:0]        cfg_pending
);

   localparam int unsigned NUM_CH = 16;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   typedef enum logic [1:0] {IDLE, POP, FULL} state_t;

   state_t             state, state_next;
   logic [SHIFT_W-1:0] active  [NUM_CH];
   logic [SHIFT_W-1:0] pending [NUM_CH];
   logic [CNT_W-1:0]   cnt      [NUM_CH];
   logic [CNT_W-1:0]   cnt_next [NUM_CH];
   logic               drop_q;

   logic               capture;
   logic               xform;
   logic               drop;
   logic               is_on;
   logic               is_off;
   logic signed [8:0]  shift_ext;
   logic signed [8:0]  note_sum;
   logic [6:0]         data1_new;

   // SysEx and busy are straight wires in both directions
   assign midi_out_sysex_data  = midi_in_sysex_data;
   assign midi_out_sysex_valid = midi_in_sysex_valid;
   assign midi_out_sysex_last  = midi_in_sysex_last;
   assign midi_in_sysex_rd     = midi_out_sysex_rd;
   assign midi_in_sysex_busy   = midi_out_sysex_busy;
   assign midi_in_midi_busy    = midi_out_midi_busy;

   assign capture = (state == IDLE) && midi_in_midi_valid;

   // Note transform using the channel's currently active shift
   always_comb begin
      xform     = 1'b0;
      drop      = 1'b0;
      data1_new = midi_in_midi_data1;
      shift_ext = 9'($signed(active[midi_in_midi_ch]));
      note_sum  = $signed({2'b00, midi_in_midi_data1}) + shift_ext;
      is_on     = (midi_in_midi_cmd == 4'h9) && (midi_in_midi_data2 != 7'd0);
      is_off    = (midi_in_midi_cmd == 4'h8) ||
                  ((midi_in_midi_cmd == 4'h9) && (midi_in_midi_data2 == 7'd0));
      if (CH_MASK[midi_in_midi_ch] &&
          ((midi_in_midi_cmd == 4'h8) || (midi_in_midi_cmd == 4'h9) ||
           (midi_in_midi_cmd == 4'hA))) begin
         xform = 1'b1;
      end
      if (xform) begin
         if (note_sum < 0) begin
            if (OOR_CLAMP) data1_new = 7'd0;
            else           drop      = 1'b1;
         end else if (note_sum > 9'sd127) begin
            if (OOR_CLAMP) data1_new = 7'd127;
            else           drop      = 1'b1;
         end else begin
            data1_new = note_sum[6:0];
         end
      end
   end

   // Active-note counters move only for messages that are actually forwarded
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         cnt_next[i] = cnt[i];
         if (capture && !drop && (midi_in_midi_ch == 4'(i))) begin
            if (is_on && (cnt[i] != CNT_MAX))
               cnt_next[i] = cnt[i] + CNT_W'(1);
            else if (is_off && (cnt[i] != '0))
               cnt_next[i] = cnt[i] - CNT_W'(1);
         end
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (midi_in_midi_valid) state_next = POP;
         POP:     state_next = drop_q ? IDLE : FULL;
         FULL:    if (midi_out_midi_rd) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state               <= IDLE;
         drop_q              <= 1'b0;
         midi_in_midi_rd     <= 1'b0;
         midi_out_midi_valid <= 1'b0;
         midi_out_midi_cmd   <= '0;
         midi_out_midi_ch    <= '0;
         midi_out_midi_data1 <= '0;
         midi_out_midi_data2 <= '0;
      end else begin
         state               <= state_next;
         midi_in_midi_rd     <= (state_next == POP);
         midi_out_midi_valid <= (state_next == FULL);
         if (capture) begin
            drop_q              <= drop;
            midi_out_midi_cmd   <= midi_in_midi_cmd;
            midi_out_midi_ch    <= midi_in_midi_ch;
            midi_out_midi_data1 <= data1_new;
            midi_out_midi_data2 <= midi_in_midi_data2;
         end
      end
   end

   // Per-channel shift bookkeeping: a pending shift lands once the channel is silent
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         notes_active <= '0;
         cfg_pending  <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            cnt[i]     <= '0;
            active[i]  <= SHIFT_W'(DEFAULT_SHIFT);
            pending[i] <= SHIFT_W'(DEFAULT_SHIFT);
         end
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            cnt[i]          <= cnt_next[i];
            notes_active[i] <= (cnt_next[i] != '0);
            if (cfg_pending[i] && (cnt[i] == '0)) begin
               active[i]      <= pending[i];
               cfg_pending[i] <= 1'b0;
            end
            if (cfg_wr && (cfg_ch == 4'(i))) begin
               pending[i]     <= cfg_shift;
               cfg_pending[i] <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_transpose_midi_ch.sv
// Scoreboard bench for transpose_midi_ch: dut_a drops out-of-range notes
// (default shift 1, ch4 masked), dut_b clamps them (default shift 0).
module tb_transpose_midi_ch;

   typedef struct packed {
      logic [3:0] cmd;
      logic [3:0] ch;
      logic [6:0] d1;
      logic [6:0] d2;
   } word_t;

   logic       aclk = 1'b0;
   logic       aresetn = 1'b0;
   logic [3:0] in_cmd = '0, in_ch = '0;
   logic [6:0] in_d1 = '0, in_d2 = '0;
   logic       in_valid = 1'b0, out_rd = 1'b0, cfg_wr = 1'b0, dsel = 1'b0;
   logic [3:0] cfg_ch = '0;
   logic [4:0] cfg_shift = '0;
   logic       midi_busy = 1'b0;
   logic [7:0] sx_data = '0;
   logic       sx_valid = 1'b0, sx_last = 1'b0, sx_rd = 1'b0, sx_busy = 1'b0;

   logic        rd_a, busy_a, ov_a, rd_b, busy_b, ov_b;
   logic [3:0]  oc_a, och_a, oc_b, och_b;
   logic [6:0]  od1_a, od2_a, od1_b, od2_b;
   logic [15:0] na_a, cp_a, na_b, cp_b;
   logic [7:0]  sxd_a, sxd_b;
   logic        sxv_a, sxl_a, sxr_a, sxb_a, sxv_b, sxl_b, sxr_b, sxb_b;

   logic        rd, ov;
   logic [15:0] pend_obs, na_obs;
   word_t       obs;

   int checks = 0;
   int errors = 0;
   int rd_pulses = 0;
   word_t sb[$];

   always #5 aclk = ~aclk;

   always @(posedge aclk) if (rd_a || rd_b) rd_pulses <= rd_pulses + 1;

   assign rd       = dsel ? rd_b : rd_a;
   assign ov       = dsel ? ov_b : ov_a;
   assign pend_obs = dsel ? cp_b : cp_a;
   assign na_obs   = dsel ? na_b : na_a;
   assign obs      = dsel ? {oc_b, och_b, od1_b, od2_b} : {oc_a, och_a, od1_a, od2_a};

   transpose_midi_ch #(.SHIFT_W(5), .DEFAULT_SHIFT(1), .CH_MASK(16'hFFEF),
                       .OOR_CLAMP(1'b0), .CNT_W(8)) dut_a (
      .aclk(aclk), .aresetn(aresetn),
      .midi_in_midi_cmd(in_cmd), .midi_in_midi_ch(in_ch),
      .midi_in_midi_data1(in_d1), .midi_in_midi_data2(in_d2),
      .midi_in_midi_valid(in_valid && !dsel), .midi_in_midi_rd(rd_a),
      .midi_in_midi_busy(busy_a),
      .midi_out_midi_cmd(oc_a), .midi_out_midi_ch(och_a),
      .midi_out_midi_data1(od1_a), .midi_out_midi_data2(od2_a),
      .midi_out_midi_valid(ov_a), .midi_out_midi_rd(out_rd && !dsel),
      .midi_out_midi_busy(midi_busy),
      .midi_in_sysex_data(sx_data), .midi_in_sysex_valid(sx_valid),
      .midi_in_sysex_last(sx_last), .midi_in_sysex_rd(sxr_a),
      .midi_in_sysex_busy(sxb_a),
      .midi_out_sysex_data(sxd_a), .midi_out_sysex_valid(sxv_a),
      .midi_out_sysex_last(sxl_a), .midi_out_sysex_rd(sx_rd),
      .midi_out_sysex_busy(sx_busy),
      .cfg_wr(cfg_wr && !dsel), .cfg_ch(cfg_ch), .cfg_shift(cfg_shift),
      .notes_active(na_a), .cfg_pending(cp_a)
   );

   transpose_midi_ch #(.SHIFT_W(5), .DEFAULT_SHIFT(0), .CH_MASK(16'hFFFF),
                       .OOR_CLAMP(1'b1), .CNT_W(8)) dut_b (
      .aclk(aclk), .aresetn(aresetn),
      .midi_in_midi_cmd(in_cmd), .midi_in_midi_ch(in_ch),
      .midi_in_midi_data1(in_d1), .midi_in_midi_data2(in_d2),
      .midi_in_midi_valid(in_valid && dsel), .midi_in_midi_rd(rd_b),
      .midi_in_midi_busy(busy_b),
      .midi_out_midi_cmd(oc_b), .midi_out_midi_ch(och_b),
      .midi_out_midi_data1(od1_b), .midi_out_midi_data2(od2_b),
      .midi_out_midi_valid(ov_b), .midi_out_midi_rd(out_rd && dsel),
      .midi_out_midi_busy(midi_busy),
      .midi_in_sysex_data(sx_data), .midi_in_sysex_valid(sx_valid),
      .midi_in_sysex_last(sx_last), .midi_in_sysex_rd(sxr_b),
      .midi_in_sysex_busy(sxb_b),
      .midi_out_sysex_data(sxd_b), .midi_out_sysex_valid(sxv_b),
      .midi_out_sysex_last(sxl_b), .midi_out_sysex_rd(sx_rd),
      .midi_out_sysex_busy(sx_busy),
      .cfg_wr(cfg_wr && dsel), .cfg_ch(cfg_ch), .cfg_shift(cfg_shift),
      .notes_active(na_b), .cfg_pending(cp_b)
   );

   task automatic cfg(input logic [3:0] ch, input logic [4:0] sh);
      @(posedge aclk); #1;
      cfg_ch = ch; cfg_shift = sh; cfg_wr = 1'b1;
      @(posedge aclk); #1;
      cfg_wr = 1'b0;
   endtask

   // Push expectation, hand one word upstream, then collect or confirm drop
   task automatic xfer(input logic [3:0] c, input logic [3:0] ch,
                       input logic [6:0] d1, input logic [6:0] d2,
                       input bit fwd, input logic [6:0] exp_d1,
                       output logic [15:0] pend_pop);
      word_t w;
      bit got;
      if (fwd) begin
         w.cmd = c; w.ch = ch; w.d1 = exp_d1; w.d2 = d2;
         sb.push_back(w);
      end
      @(posedge aclk); #1;
      in_cmd = c; in_ch = ch; in_d1 = d1; in_d2 = d2; in_valid = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 8 && !got; k++) begin
         @(negedge aclk);
         if (rd) got = 1'b1;
      end
      in_valid = 1'b0;
      pend_pop = pend_obs;
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL in_rd_timeout ch=%0d d1=%0d: rd never seen, required 1", ch, d1);
      end
      got = 1'b0;
      for (int k = 0; k < (fwd ? 8 : 4) && !got; k++) begin
         @(negedge aclk);
         if (ov) got = 1'b1;
      end
      checks++;
      if (fwd) begin
         w = sb.pop_front();
         if (!got) begin
            errors++;
            $display("FAIL out_valid_timeout ch=%0d: out_valid 0, required 1", ch);
         end else begin
            if (obs !== w) begin
               errors++;
               $display("FAIL word ch=%0d: got %h/%h/%0d/%0d, required %h/%h/%0d/%0d",
                        ch, obs.cmd, obs.ch, obs.d1, obs.d2, w.cmd, w.ch, w.d1, w.d2);
            end
            out_rd = 1'b1;
            @(negedge aclk);
            out_rd = 1'b0;
         end
      end else if (got) begin
         errors++;
         $display("FAIL drop ch=%0d d1=%0d: out_valid 1, required 0", ch, d1);
      end
   endtask

   task automatic test_reset();
      aresetn = 1'b0;
      #1;
      checks++;
      if (ov_a !== 1'b0 || rd_a !== 1'b0 || obs !== '0 || na_a !== '0 || cp_a !== '0) begin
         errors++;
         $display("FAIL reset: ov=%b rd=%b word=%h na=%h cp=%h, required all 0",
                  ov_a, rd_a, obs, na_a, cp_a);
      end
      repeat (3) @(negedge aclk);
      aresetn = 1'b1;
   endtask

   task automatic test_basic();
      word_t w;
      int rd0;
      logic [15:0] p;
      w.cmd = 4'h9; w.ch = 4'h0; w.d1 = 7'd61; w.d2 = 7'd100;
      sb.push_back(w);
      @(posedge aclk); #1;
      rd0 = rd_pulses;
      in_cmd = 4'h9; in_ch = 4'h0; in_d1 = 7'd60; in_d2 = 7'd100; in_valid = 1'b1;
      @(negedge aclk);
      checks++;
      if (rd !== 1'b0 || ov !== 1'b0) begin
         errors++; $display("FAIL cycle0: rd=%b ov=%b, required 0 0", rd, ov);
      end
      @(negedge aclk);
      checks++;
      if (rd !== 1'b1 || ov !== 1'b0) begin
         errors++; $display("FAIL cycle1: rd=%b ov=%b, required 1 0", rd, ov);
      end
      in_valid = 1'b0;
      @(negedge aclk);
      w = sb.pop_front();
      checks++;
      if (rd !== 1'b0 || ov !== 1'b1 || obs !== w) begin
         errors++;
         $display("FAIL cycle2: rd=%b ov=%b word=%h, required 0 1 %h", rd, ov, obs, w);
      end
      checks++;
      if (na_obs[0] !== 1'b1) begin
         errors++; $display("FAIL notes_active0: %b, required 1", na_obs[0]);
      end
      out_rd = 1'b1;
      @(negedge aclk);
      out_rd = 1'b0;
      checks++;
      if (ov !== 1'b0 || (rd_pulses - rd0) != 1) begin
         errors++;
         $display("FAIL pop_once: ov=%b rd_pulses=%0d, required 0 1", ov, rd_pulses - rd0);
      end
      xfer(4'h8, 4'h0, 7'd60, 7'd64, 1'b1, 7'd61, p);
      checks++;
      if (na_obs[0] !== 1'b0) begin
         errors++; $display("FAIL notes_active0_off: %b, required 0", na_obs[0]);
      end
   endtask

   task automatic test_shift();
      logic [15:0] p;
      cfg(4'd3, 5'(-12));
      checks++;
      if (cp_a[3] !== 1'b1) begin
         errors++; $display("FAIL cfg_pending3_set: %b, required 1", cp_a[3]);
      end
      xfer(4'h9, 4'd3, 7'd64, 7'd90, 1'b1, 7'd52, p);
      checks++;
      if (cp_a[3] !== 1'b0) begin
         errors++; $display("FAIL cfg_pending3_clr: %b, required 0", cp_a[3]);
      end
      xfer(4'h9, 4'd4, 7'd64, 7'd90, 1'b1, 7'd64, p);
      xfer(4'hB, 4'd3, 7'd64, 7'd10, 1'b1, 7'd64, p);
      xfer(4'hA, 4'd3, 7'd64, 7'd33, 1'b1, 7'd52, p);
      xfer(4'h8, 4'd3, 7'd64, 7'd0, 1'b1, 7'd52, p);
      xfer(4'h8, 4'd4, 7'd64, 7'd0, 1'b1, 7'd64, p);
   endtask

   task automatic test_oor();
      logic [15:0] p;
      cfg(4'd5, 5'd5);
      cfg(4'd6, 5'(-16));
      xfer(4'h9, 4'd5, 7'd125, 7'd80, 1'b0, 7'd0, p);
      checks++;
      if (na_a[5] !== 1'b0) begin
         errors++; $display("FAIL drop_counter: na5=%b, required 0", na_a[5]);
      end
      xfer(4'h9, 4'd6, 7'd10, 7'd80, 1'b0, 7'd0, p);
      xfer(4'h9, 4'd5, 7'd122, 7'd80, 1'b1, 7'd127, p);
      xfer(4'h8, 4'd5, 7'd122, 7'd0, 1'b1, 7'd127, p);
      dsel = 1'b1;
      cfg(4'd5, 5'd5);
      cfg(4'd6, 5'(-16));
      xfer(4'h9, 4'd5, 7'd125, 7'd80, 1'b1, 7'd127, p);
      xfer(4'h9, 4'd6, 7'd10, 7'd80, 1'b1, 7'd0, p);
      xfer(4'h9, 4'd8, 7'd127, 7'd80, 1'b1, 7'd127, p);
      checks++;
      if (na_b[5] !== 1'b1 || na_b[6] !== 1'b1) begin
         errors++; $display("FAIL clamp_counter: na=%h, required bits 5,6 set", na_b);
      end
      dsel = 1'b0;
   endtask

   task automatic test_deferred();
      logic [15:0] p;
      cfg(4'd2, 5'd2);
      xfer(4'h9, 4'd2, 7'd60, 7'd100, 1'b1, 7'd62, p);
      cfg(4'd2, 5'd7);
      checks++;
      if (cp_a[2] !== 1'b1) begin
         errors++; $display("FAIL deferred_pending: %b, required 1", cp_a[2]);
      end
      xfer(4'h8, 4'd2, 7'd60, 7'd0, 1'b1, 7'd62, p);
      checks++;
      if (p[2] !== 1'b1 || cp_a[2] !== 1'b0) begin
         errors++;
         $display("FAIL deferred_transfer: pend_at_pop=%b now=%b, required 1 0", p[2], cp_a[2]);
      end
      xfer(4'h9, 4'd2, 7'd60, 7'd100, 1'b1, 7'd67, p);
      xfer(4'h8, 4'd2, 7'd60, 7'd0, 1'b1, 7'd67, p);
   endtask

   task automatic test_velocity_zero();
      logic [15:0] p;
      xfer(4'h9, 4'd7, 7'd50, 7'd90, 1'b1, 7'd51, p);
      checks++;
      if (na_a[7] !== 1'b1) begin
         errors++; $display("FAIL vel_on: na7=%b, required 1", na_a[7]);
      end
      xfer(4'h9, 4'd7, 7'd50, 7'd0, 1'b1, 7'd51, p);
      checks++;
      if (na_a[7] !== 1'b0) begin
         errors++; $display("FAIL vel_zero: na7=%b, required 0", na_a[7]);
      end
      xfer(4'h8, 4'd7, 7'd50, 7'd0, 1'b1, 7'd51, p);
      checks++;
      if (na_a[7] !== 1'b0) begin
         errors++; $display("FAIL off_at_zero: na7=%b, required 0", na_a[7]);
      end
   endtask

   task automatic test_hold_reset();
      word_t w;
      bit got, stable, rd_seen;
      w.cmd = 4'h9; w.ch = 4'd1; w.d1 = 7'd41; w.d2 = 7'd70;
      sb.push_back(w);
      @(posedge aclk); #1;
      in_cmd = 4'h9; in_ch = 4'd1; in_d1 = 7'd40; in_d2 = 7'd70; in_valid = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 8 && !got; k++) begin
         @(negedge aclk);
         if (ov) got = 1'b1;
      end
      in_d1 = 7'd99;
      w = sb.pop_front();
      checks++;
      if (!got || obs !== w) begin
         errors++; $display("FAIL hold_first: ov=%b word=%h, required 1 %h", got, obs, w);
      end
      stable = 1'b1; rd_seen = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge aclk);
         if (ov !== 1'b1 || obs !== w) stable = 1'b0;
         if (rd !== 1'b0) rd_seen = 1'b1;
      end
      checks++;
      if (!stable || rd_seen) begin
         errors++; $display("FAIL hold: stable=%b rd_seen=%b, required 1 0", stable, rd_seen);
      end
      #2;
      aresetn = 1'b0;
      #1;
      checks++;
      if (ov !== 1'b0 || na_a !== '0 || obs !== '0) begin
         errors++;
         $display("FAIL reset_full: ov=%b na=%h word=%h, required 0 0 0", ov, na_a, obs);
      end
      in_valid = 1'b0;
      @(negedge aclk);
      aresetn = 1'b1;
   endtask

   task automatic test_sysex();
      for (int k = 0; k < 2; k++) begin
         sx_data = (k == 0) ? 8'hF0 : 8'h5A;
         sx_valid = (k == 0); sx_last = (k != 0);
         sx_rd = (k == 0); sx_busy = (k != 0); midi_busy = (k == 0);
         #1;
         checks++;
         if (sxd_a !== sx_data || sxv_a !== sx_valid || sxl_a !== sx_last ||
             sxr_a !== sx_rd || sxb_a !== sx_busy || busy_a !== midi_busy ||
             sxd_b !== sx_data || sxv_b !== sx_valid || sxl_b !== sx_last ||
             sxr_b !== sx_rd || sxb_b !== sx_busy || busy_b !== midi_busy) begin
            errors++;
            $display("FAIL sysex%0d: got %h %b%b%b%b%b, required %h %b%b%b%b%b", k,
                     sxd_a, sxv_a, sxl_a, sxr_a, sxb_a, busy_a,
                     sx_data, sx_valid, sx_last, sx_rd, sx_busy, midi_busy);
         end
      end
      midi_busy = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_shift();
      test_oor();
      test_deferred();
      test_velocity_zero();
      test_hold_reset();
      test_sysex();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
